// File: rtl/stage_mem_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stage_pkg
// Brief    : Shared encodings, FSM state type and legality helper for the LSU.
// Revision : 1.0
// ============================================================================
package stage_pkg;

    localparam logic [1:0] RS_PC  = 2'b00;
    localparam logic [1:0] RS_ALU = 2'b01;
    localparam logic [1:0] RS_MEM = 2'b10;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    // Stores only exist for B/H/W; unsigned codes are load-only.
    function automatic logic access_legal(input logic       is_store,
                                          input logic [2:0] f3,
                                          input logic [1:0] off);
        logic ok;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~off[0];
            F3_W:    ok = (off == 2'b00);
            F3_BU:   ok = ~is_store;
            F3_HU:   ok = ~is_store & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stage_mem_lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Brief    : Selects the load lane from a read word and sign/zero extends it.
// Revision : 1.0
// ============================================================================
module lsu_align
    import stage_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_offset)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_W:    o_data = i_rdata;
            F3_BU:   o_data = {24'd0, w_byte};
            F3_HU:   o_data = {16'd0, w_half};
            default: o_data = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/stage_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : stage_mem_lsu
// Brief    : MEM pipeline stage: single-outstanding load/store unit with timeout.
// Revision : 1.0
// ============================================================================
module stage_mem_lsu
    import stage_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int ALU_RESULT_WIDTH = 32,
    parameter int PC_WIDTH         = 32,
    parameter int RESULTSRC_WIDTH  = 2,
    parameter int TIMEOUT          = TIMEOUT_DEFAULT
)(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        valid_in,
    input  logic [RESULTSRC_WIDTH-1:0]  ResultSrc,
    input  logic                        MemWrite,
    input  logic [2:0]                  funct3,
    input  logic [ALU_RESULT_WIDTH-1:0] ALU_result,
    input  logic [DATA_WIDTH-1:0]       write_data,
    input  logic [PC_WIDTH-1:0]         pc_add_1,
    output logic                        stall,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [31:0]                 mem_addr,
    output logic [31:0]                 mem_wdata,
    output logic [3:0]                  mem_be,
    input  logic                        mem_ack,
    input  logic [31:0]                 mem_rdata,
    output logic                        valid_out,
    output logic [RESULTSRC_WIDTH-1:0]  ResultSrc_out,
    output logic [DATA_WIDTH-1:0]       read_data,
    output logic [ALU_RESULT_WIDTH-1:0] ALU_result_out,
    output logic [PC_WIDTH-1:0]         pc_add_1_out,
    output logic                        access_err
);

    localparam int             CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        mem_req_q, mem_req_d;
    logic                        mem_we_q, mem_we_d;
    logic [31:0]                 mem_addr_q, mem_addr_d;
    logic [31:0]                 mem_wdata_q, mem_wdata_d;
    logic [3:0]                  mem_be_q, mem_be_d;
    logic [2:0]                  f3_q, f3_d;
    logic [1:0]                  off_q, off_d;
    logic                        is_load_q, is_load_d;
    logic                        valid_out_q, valid_out_d;
    logic [RESULTSRC_WIDTH-1:0]  rs_out_q, rs_out_d;
    logic [ALU_RESULT_WIDTH-1:0] alu_out_q, alu_out_d;
    logic [PC_WIDTH-1:0]         pc_out_q, pc_out_d;
    logic [DATA_WIDTH-1:0]       rd_q, rd_d;
    logic                        err_q, err_d;

    logic                        w_mem_op;
    logic                        w_legal;
    logic [31:0]                 w_st_wdata;
    logic [3:0]                  w_st_be;
    logic [31:0]                 w_load_word;

    assign w_mem_op = valid_in & (MemWrite | (ResultSrc == RESULTSRC_WIDTH'(RS_MEM)));
    assign w_legal  = access_legal(MemWrite, funct3, ALU_result[1:0]);

    // Loads enable the whole word; the lane is picked on return.
    always_comb begin
        w_st_wdata = write_data[31:0];
        w_st_be    = 4'hF;
        if (MemWrite) begin
            case (funct3)
                F3_B: begin
                    w_st_wdata = {4{write_data[7:0]}};
                    w_st_be    = 4'b0001 << ALU_result[1:0];
                end
                F3_H: begin
                    w_st_wdata = {2{write_data[15:0]}};
                    w_st_be    = ALU_result[1] ? 4'b1100 : 4'b0011;
                end
                default: ;
            endcase
        end
    end

    lsu_align u_align (
        .i_rdata  (mem_rdata),
        .i_offset (off_q),
        .i_funct3 (f3_q),
        .o_data   (w_load_word)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        f3_d        = f3_q;
        off_d       = off_q;
        is_load_d   = is_load_q;
        valid_out_d = 1'b0;
        rs_out_d    = rs_out_q;
        alu_out_d   = alu_out_q;
        pc_out_d    = pc_out_q;
        rd_d        = rd_q;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    rs_out_d  = ResultSrc;
                    alu_out_d = ALU_result;
                    pc_out_d  = pc_add_1;
                    rd_d      = '0;
                end
                if (w_mem_op && w_legal) begin
                    state_d     = BUSY;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = MemWrite;
                    mem_addr_d  = {ALU_result[31:2], 2'b00};
                    mem_wdata_d = w_st_wdata;
                    mem_be_d    = w_st_be;
                    f3_d        = funct3;
                    off_d       = ALU_result[1:0];
                    is_load_d   = ~MemWrite;
                end else if (w_mem_op) begin
                    state_d     = DONE;
                    valid_out_d = 1'b1;
                    err_d       = 1'b1;
                end else if (valid_in) begin
                    valid_out_d = 1'b1;
                end
            end
            BUSY: begin
                // An ack on the final counted cycle still completes cleanly.
                if (mem_ack) begin
                    state_d     = DONE;
                    valid_out_d = 1'b1;
                    rd_d        = is_load_q ? DATA_WIDTH'(w_load_word) : '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = DONE;
                    valid_out_d = 1'b1;
                    err_d       = 1'b1;
                    rd_d        = '0;
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    mem_req_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            f3_q        <= '0;
            off_q       <= '0;
            is_load_q   <= 1'b0;
            valid_out_q <= 1'b0;
            rs_out_q    <= '0;
            alu_out_q   <= '0;
            pc_out_q    <= '0;
            rd_q        <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            is_load_q   <= is_load_d;
            valid_out_q <= valid_out_d;
            rs_out_q    <= rs_out_d;
            alu_out_q   <= alu_out_d;
            pc_out_q    <= pc_out_d;
            rd_q        <= rd_d;
            err_q       <= err_d;
        end
    end

    // Gated by rst_n so every output reads 0 while reset is held.
    assign stall = rst_n & (((state_q == IDLE) & w_mem_op) | (state_q == BUSY));

    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_be         = mem_be_q;
    assign valid_out      = valid_out_q;
    assign ResultSrc_out  = rs_out_q;
    assign read_data      = rd_q;
    assign ALU_result_out = alu_out_q;
    assign pc_add_1_out   = pc_out_q;
    assign access_err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_stage_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage_mem_lsu
// Brief    : Directed, table-driven bench for the MEM-stage load/store unit.
// Revision : 1.0
// ============================================================================
module tb_stage_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic [1:0]  ResultSrc = 2'b00;
    logic        MemWrite = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] ALU_result = '0;
    logic [31:0] write_data = '0;
    logic [31:0] pc_add_1 = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        stall, mem_req, mem_we, valid_out, access_err;
    logic [31:0] mem_addr, mem_wdata, read_data, ALU_result_out, pc_add_1_out;
    logic [3:0]  mem_be;
    logic [1:0]  ResultSrc_out;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    stage_mem_lsu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_in       (valid_in),
        .ResultSrc      (ResultSrc),
        .MemWrite       (MemWrite),
        .funct3         (funct3),
        .ALU_result     (ALU_result),
        .write_data     (write_data),
        .pc_add_1       (pc_add_1),
        .stall          (stall),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_be         (mem_be),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .valid_out      (valid_out),
        .ResultSrc_out  (ResultSrc_out),
        .read_data      (read_data),
        .ALU_result_out (ALU_result_out),
        .pc_add_1_out   (pc_add_1_out),
        .access_err     (access_err)
    );

    typedef struct {
        logic [1:0]  rs;
        logic        mw;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc;
        logic [31:0] rdata;
        int          ack_at;   // BUSY cycle carrying mem_ack; 0 = never
        logic        is_mem;
        logic        legal;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
        logic [31:0] e_rd;
        logic        e_err;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input int idx, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL vec%0d %s: got 0x%08h expected 0x%08h", idx, nm, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  k;
        bit  done;
        @(negedge clk);
        valid_in   = 1'b1;
        ResultSrc  = v.rs;
        MemWrite   = v.mw;
        funct3     = v.f3;
        ALU_result = v.alu;
        write_data = v.wd;
        pc_add_1   = v.pc;
        mem_rdata  = '0;
        #1;
        chk(idx, "stall_accept", {31'd0, stall}, {31'd0, v.is_mem});
        chk(idx, "req_accept", {31'd0, mem_req}, 32'd0);
        if (v.is_mem && v.legal) begin
            k    = 0;
            done = 1'b0;
            while (!done) begin
                @(negedge clk);
                valid_in = 1'b0;
                k++;
                #1;
                chk(idx, "busy_req", {31'd0, mem_req}, 32'd1);
                chk(idx, "busy_stall", {31'd0, stall}, 32'd1);
                chk(idx, "busy_addr", mem_addr, v.e_addr);
                chk(idx, "busy_be", {28'd0, mem_be}, {28'd0, v.e_be});
                chk(idx, "busy_we", {31'd0, mem_we}, {31'd0, v.mw});
                if (v.mw) chk(idx, "busy_wdata", mem_wdata, v.e_wdata);
                chk(idx, "busy_valid", {31'd0, valid_out}, 32'd0);
                if (k == v.ack_at) begin
                    mem_ack   = 1'b1;
                    mem_rdata = v.rdata;
                    done      = 1'b1;
                end else if (k == 16) begin
                    done = 1'b1;
                end
            end
        end
        @(negedge clk);
        valid_in  = 1'b0;
        mem_ack   = 1'b1;              // stray ack while in DONE/IDLE
        mem_rdata = 32'h5A5A_5A5A;
        #1;
        chk(idx, "done_valid", {31'd0, valid_out}, 32'd1);
        chk(idx, "done_req", {31'd0, mem_req}, 32'd0);
        chk(idx, "done_stall", {31'd0, stall}, 32'd0);
        chk(idx, "done_err", {31'd0, access_err}, {31'd0, v.e_err});
        chk(idx, "done_rdata", read_data, v.e_rd);
        chk(idx, "done_alu", ALU_result_out, v.alu);
        chk(idx, "done_pc", pc_add_1_out, v.pc);
        chk(idx, "done_rs", {30'd0, ResultSrc_out}, {30'd0, v.rs});
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk(idx, "after_valid", {31'd0, valid_out}, 32'd0);
        chk(idx, "after_err", {31'd0, access_err}, 32'd0);
        chk(idx, "after_req", {31'd0, mem_req}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            rs     mw   f3      alu            wd             pc             rdata          ack mem legal e_addr        e_wdata        e_be     e_rd           err
        vecs[0]  = '{2'b01, 1'b0, 3'b000, 32'h0000_1234, 32'h0,         32'h0000_0040, 32'h0,         0,  1'b0, 1'b1, 32'h0,        32'h0,         4'h0,    32'h0,         1'b0};
        vecs[1]  = '{2'b10, 1'b0, 3'b000, 32'h0000_0103, 32'h0,         32'h0000_0044, 32'h80FF_0000, 3,  1'b1, 1'b1, 32'h0000_0100, 32'h0,        4'hF,    32'hFFFF_FF80, 1'b0};
        vecs[2]  = '{2'b00, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0000_0048, 32'h0,         2,  1'b1, 1'b1, 32'h0000_0200, 32'hABCD_ABCD, 4'b1100, 32'h0,        1'b0};
        vecs[3]  = '{2'b10, 1'b0, 3'b010, 32'h0000_0301, 32'h0,         32'h0000_004C, 32'h0,         0,  1'b1, 1'b0, 32'h0,        32'h0,         4'h0,    32'h0,         1'b1};
        vecs[4]  = '{2'b10, 1'b0, 3'b010, 32'h0000_0300, 32'h0,         32'h0000_0050, 32'h0,         0,  1'b1, 1'b1, 32'h0000_0300, 32'h0,        4'hF,    32'h0,         1'b1};
        vecs[5]  = '{2'b10, 1'b0, 3'b010, 32'h0000_0304, 32'h0,         32'h0000_0054, 32'hDEAD_BEEF, 16, 1'b1, 1'b1, 32'h0000_0304, 32'h0,        4'hF,    32'hDEAD_BEEF, 1'b0};
        vecs[6]  = '{2'b10, 1'b0, 3'b101, 32'h0000_010A, 32'h0,         32'h0000_0058, 32'h8765_4321, 1,  1'b1, 1'b1, 32'h0000_0108, 32'h0,        4'hF,    32'h0000_8765, 1'b0};
        vecs[7]  = '{2'b10, 1'b0, 3'b001, 32'h0000_010A, 32'h0,         32'h0000_005C, 32'h8765_4321, 1,  1'b1, 1'b1, 32'h0000_0108, 32'h0,        4'hF,    32'hFFFF_8765, 1'b0};
        vecs[8]  = '{2'b10, 1'b0, 3'b100, 32'h0000_0101, 32'h0,         32'h0000_0060, 32'h1234_80AB, 2,  1'b1, 1'b1, 32'h0000_0100, 32'h0,        4'hF,    32'h0000_0080, 1'b0};
        vecs[9]  = '{2'b00, 1'b1, 3'b000, 32'h0000_0005, 32'h1234_56C3, 32'h0000_0064, 32'h0,         1,  1'b1, 1'b1, 32'h0000_0004, 32'hC3C3_C3C3, 4'b0010, 32'h0,        1'b0};
        vecs[10] = '{2'b00, 1'b1, 3'b010, 32'h0000_0008, 32'hCAFE_F00D, 32'h0000_0068, 32'h0,         1,  1'b1, 1'b1, 32'h0000_0008, 32'hCAFE_F00D, 4'hF,    32'h0,        1'b0};
        vecs[11] = '{2'b10, 1'b0, 3'b011, 32'h0000_0400, 32'h0,         32'h0000_006C, 32'h0,         0,  1'b1, 1'b0, 32'h0,        32'h0,         4'h0,    32'h0,         1'b1};
        vecs[12] = '{2'b00, 1'b0, 3'b000, 32'h0000_0077, 32'h0,         32'h0000_0088, 32'h0,         0,  1'b0, 1'b1, 32'h0,        32'h0,         4'h0,    32'h0,         1'b0};

        // Reset state
        @(negedge clk);
        #1;
        chk(-1, "rst_req", {31'd0, mem_req}, 32'd0);
        chk(-1, "rst_valid", {31'd0, valid_out}, 32'd0);
        chk(-1, "rst_err", {31'd0, access_err}, 32'd0);
        chk(-1, "rst_stall", {31'd0, stall}, 32'd0);
        chk(-1, "rst_rdata", read_data, 32'd0);
        chk(-1, "rst_be", {28'd0, mem_be}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

        // Reset dropped mid-BUSY aborts the load with no completion.
        @(negedge clk);
        valid_in   = 1'b1;
        ResultSrc  = 2'b10;
        MemWrite   = 1'b0;
        funct3     = 3'b010;
        ALU_result = 32'h0000_0400;
        @(negedge clk);
        valid_in = 1'b0;
        #1;
        chk(100, "abort_req_before", {31'd0, mem_req}, 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk(100, "abort_req", {31'd0, mem_req}, 32'd0);
        chk(100, "abort_valid", {31'd0, valid_out}, 32'd0);
        chk(100, "abort_stall", {31'd0, stall}, 32'd0);
        chk(100, "abort_addr", mem_addr, 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        mem_ack = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            #1;
            chk(100, "post_rst_valid", {31'd0, valid_out}, 32'd0);
            chk(100, "post_rst_req", {31'd0, mem_req}, 32'd0);
            chk(100, "post_rst_err", {31'd0, access_err}, 32'd0);
        end
        mem_ack = 1'b0;
        run_vec(101, vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stage_mem_lsu.md
STAGE_MEM_LSU -- requirements
Module: stage_mem_lsu

Interface
REQ-001 SHALL have parameters: DATA_WIDTH 32 (data bus); ALU_RESULT_WIDTH 32 (address/ALU value); PC_WIDTH 32 (pc_add_1 width); RESULTSRC_WIDTH 2 (ResultSrc width); TIMEOUT 16 (max cycles awaiting mem_ack).
REQ-002 SHALL have ports, in this order (clock and reset first):
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  EX-side operation valid.
- ResultSrc  in  RESULTSRC_WIDTH  00 = PC, 01 = ALU, 10 = memory load.
- MemWrite  in  1  store operation.
- funct3  in  3  access size and signedness.
- ALU_result  in  ALU_RESULT_WIDTH  effective address or ALU value.
- write_data  in  DATA_WIDTH  store data.
- pc_add_1  in  PC_WIDTH  passthrough.
- stall  out  1  EX must hold its inputs.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- mem_addr  out  32  word-aligned address.
- mem_wdata  out  32  store data, lane-aligned.
- mem_be  out  4  byte enables.
- mem_ack  in  1  memory response strobe.
- mem_rdata  in  32  read word.
- valid_out  out  1  WB-side result valid.
- ResultSrc_out  out  RESULTSRC_WIDTH  to WB.
- read_data  out  DATA_WIDTH  formatted load data.
- ALU_result_out  out  ALU_RESULT_WIDTH  to WB.
- pc_add_1_out  out  PC_WIDTH  to WB.
- access_err  out  1  one-cycle pulse: misaligned access, illegal funct3, or timeout.

Function
REQ-003 SHALL define a memory op as valid_in & (MemWrite | ResultSrc==2'b10); all other valid_in is a passthrough op.
REQ-004 SHALL register a passthrough op in IDLE to the WB outputs with latency 1: valid_out=1 for one cycle, read_data=0.
REQ-005 SHALL use FSM states IDLE, BUSY, DONE.
- IDLE -> BUSY on a legal memory op.
- BUSY -> DONE on mem_ack, or on timeout.
- DONE -> IDLE unconditionally.
REQ-006 SHALL drive stall = (IDLE & memory op) | BUSY; inputs presented in BUSY or DONE are ignored.
REQ-007 SHALL drive mem_req=1 exactly while in BUSY; mem_we, mem_addr, mem_wdata and mem_be SHALL be registered at accept and held stable through BUSY.
REQ-008 SHALL form mem_addr = {ALU_result[31:2], 2'b00}.
REQ-009 SHALL apply these store rules:
- SB (000): be = 1<<addr[1:0]; byte replicated to all four lanes.
- SH (001): be = 0011 if addr[1]=0, else 1100; halfword replicated to both halves.
- SW (010): be = 1111.
REQ-010 SHALL apply these load rules to the lane selected by addr[1:0]:
- LB 000 and LH 001: sign-extend.
- LW 010: full word.
- LBU 100 and LHU 101: zero-extend.
- For loads, mem_be SHALL be 1111.
REQ-011 SHALL treat as illegal: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; any other funct3 value.
REQ-012 On an illegal memory op in IDLE, SHALL issue no bus request, pulse access_err, and go to DONE with read_data=0; stall SHALL be asserted for that cycle.
REQ-013 SHALL count BUSY cycles; if the count reaches TIMEOUT without mem_ack, SHALL drop mem_req, pulse access_err and go to DONE with read_data=0.
REQ-014 If mem_ack arrives in the same cycle the timeout count reaches TIMEOUT, mem_ack SHALL win and access_err SHALL stay 0.
REQ-015 SHALL ignore mem_ack outside BUSY.
REQ-016 In DONE, SHALL assert valid_out=1 for one cycle with the captured ResultSrc_out, ALU_result_out, pc_add_1_out and read_data (stores: read_data=0).
REQ-017 SHALL present all outputs except stall from registers.

Reset
REQ-018 On rst_n low, at any time including mid-transaction, SHALL immediately force:
- state = IDLE; timeout counter = 0.
- All outputs 0, including mem_req, valid_out and access_err.
- No completion is reported for an aborted transaction.
REQ-019 SHALL resume operation on the first rising clk edge after rst_n deasserts.

Structure
REQ-020 SHALL place in shared package stage_pkg: ResultSrc encodings, funct3 load/store codes, FSM state type, and TIMEOUT default.
REQ-021 SHALL implement lane extraction and sign/zero extension in one combinational sub-module, lsu_align, instantiated once.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Passthrough: ResultSrc=01, ALU_result=0x1234 -> valid_out=1 next cycle, ALU_result_out=0x1234, mem_req never 1, stall=0.
- Load with wait: LB at addr 0x103, mem_rdata=0x80FF_0000, ack after 3 cycles -> mem_addr=0x100, read_data=0xFFFF_FF80, stall high 4 cycles, valid_out one cycle after ack.
- Store: SH at 0x202 with write_data=0xABCD -> mem_be=1100, mem_wdata=0xABCD_ABCD, mem_we=1, held until ack.
- Errors: LW at 0x301 -> access_err pulse, mem_req stays 0. No ack for 16 cycles -> mem_req drops, access_err=1. Ack on cycle 16 -> no access_err.
- Reset mid-BUSY: drop rst_n -> mem_req=0, valid_out=0 immediately. After release, a new passthrough op completes normally.
